// File: rtl/regfile_sb_pkg.sv
// Shared widths and constants for the integer register file and its
// pending-write scoreboard.
package regfile_sb_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;
  localparam int SB_CNT_BUS   = 2;

  localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
  localparam logic                    TRUE         = 1'b1;
  localparam logic                    FALSE        = 1'b0;

endpackage

// File: rtl/regfile_sb_sb_counter.sv
// Saturating up/down pending-writer counter for one architectural register.
// Increment is dropped at saturation, decrement is dropped at zero.
module sb_counter
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = SB_CNT_BUS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             do_inc;
  logic             do_dec;

  assign sat  = (cnt_reg == {CNT_W{1'b1}});
  assign zero = (cnt_reg == '0);
  assign cnt  = cnt_reg;

  // Simultaneous issue and retire to the same register cancel out.
  always_comb begin
    do_inc   = inc && !sat;
    do_dec   = dec && !zero;
    cnt_next = cnt_reg;
    if (do_inc && !do_dec) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else if (do_dec && !do_inc) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 32-entry integer register file with two combinational read ports and a
// pending-write scoreboard. Define REGFILE_BYPASS_EN to forward WB data to reads.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = REG_BUS,
  parameter int ADDR_W  = REG_ADDR_BUS,
  parameter int CNT_W   = SB_CNT_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              wb_w_req,
  input  logic [ADDR_W-1:0] wb_w_addr,
  input  logic [DATA_W-1:0] wb_w_data,
  input  logic              id_issue,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_hazard,
  output logic              rs2_hazard,
  output logic              sb_err
);

  logic [DATA_W-1:0] rf_mem [REG_NUM];
  logic [CNT_W-1:0]  cnt_arr [REG_NUM];
  logic [REG_NUM-1:0] sat_vec;
  logic [REG_NUM-1:0] zero_vec;
  logic               sb_err_reg;
  logic               wb_valid;
  logic [ADDR_W-1:0]  rd_addr [2];

  assign wb_valid = wb_w_req && (wb_w_addr != ADDR_W'(NOP_REG_ADDR));

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!rst_n) begin
        for (int i = 0; i < REG_NUM; i++) begin
          rf_mem[i] <= DATA_W'(ZERO_WORD);
        end
      end else if (wb_valid) begin
        rf_mem[wb_w_addr] <= wb_w_data;
      end
    end
  end

  // x0 never has writers in flight.
  assign cnt_arr[0]  = '0;
  assign sat_vec[0]  = FALSE;
  assign zero_vec[0] = TRUE;

  genvar gi;
  generate
    for (gi = 1; gi < REG_NUM; gi++) begin : g_cnt
      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .inc   (id_issue && (id_rd == ADDR_W'(gi))),
        .dec   (wb_w_req && (wb_w_addr == ADDR_W'(gi))),
        .cnt   (cnt_arr[gi]),
        .sat   (sat_vec[gi]),
        .zero  (zero_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!rst_n) begin
        sb_err_reg <= FALSE;
      end else if (id_issue && (id_rd != '0) && sat_vec[id_rd]) begin
        sb_err_reg <= TRUE;
      end
    end
  end

  assign sb_err     = sb_err_reg;
  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] data;
      logic              hazard;
`ifdef REGFILE_BYPASS_EN
      logic              wb_hit;
      assign wb_hit = wb_w_req && (wb_w_addr == rd_addr[gi]);
`endif
      always_comb begin
        data   = rf_mem[rd_addr[gi]];
        hazard = !zero_vec[rd_addr[gi]];
        if (rd_addr[gi] == '0) begin
          data   = '0;
          hazard = FALSE;
        end
`ifdef REGFILE_BYPASS_EN
        // The last in-flight write landing now is consumed through the bypass.
        else if (wb_hit) begin
          data   = wb_w_data;
          hazard = !zero_vec[rd_addr[gi]] && (cnt_arr[rd_addr[gi]] != CNT_W'(1));
        end
`endif
      end
    end
  endgenerate

  assign rs1_data   = g_rd[0].data;
  assign rs2_data   = g_rd[1].data;
  assign rs1_hazard = g_rd[0].hazard;
  assign rs2_hazard = g_rd[1].hazard;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb; expectations follow the build's
// REGFILE_BYPASS_EN setting.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        wb_w_req;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        id_issue;
  logic [4:0]  id_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_hazard;
  logic        rs2_hazard;
  logic        sb_err;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .wb_w_req   (wb_w_req),
    .wb_w_addr  (wb_w_addr),
    .wb_w_data  (wb_w_data),
    .id_issue   (id_issue),
    .id_rd      (id_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_hazard (rs1_hazard),
    .rs2_hazard (rs2_hazard),
    .sb_err     (sb_err)
  );

  localparam int S_RS1 = 0, S_RS2 = 1, S_H1 = 2, S_H2 = 3, S_ERR = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      S_RS1:   return rs1_data;
      S_RS2:   return rs2_data;
      S_H1:    return {31'b0, rs1_hazard};
      S_H2:    return {31'b0, rs2_hazard};
      default: return {31'b0, sb_err};
    endcase
  endfunction

  task automatic push(string n, int s, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_w_req = 1'b0;
    id_issue = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    rdy = 1'b1; rst_n = 1'b0; idle();
    wb_w_addr = '0; wb_w_data = '0; id_rd = '0; rs1_addr = '0; rs2_addr = '0;
    tick();
    tick();
    rst_n = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd31;
    push("reset_rs1", S_RS1, 32'h0);
    push("reset_rs2_x31", S_RS2, 32'h0);
    push("reset_h1", S_H1, 32'h0);
    push("reset_h2", S_H2, 32'h0);
    push("reset_err", S_ERR, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd0; wb_w_data = 32'hDEADBEEF; rs2_addr = 5'd0;
    push("x0_same_cycle", S_RS1, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    idle();
    push("x0_after_write", S_RS1, 32'h0);
    push("x0_after_write_p2", S_RS2, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [31:0] obs;
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd5; wb_w_data = 32'h12345678;
    tick();
    idle(); rs1_addr = 5'd5;
    push("wr_x5_data", S_RS1, 32'h12345678);
    push("wr_x5_hazard", S_H1, 32'h0);
    push("wr_cnt0_no_err", S_ERR, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] obs;
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd7; wb_w_data = 32'hA5A5A5A5; rs2_addr = 5'd7;
    push("bypass_same_cycle", S_RS2, BYPASS ? 32'hA5A5A5A5 : 32'h0);
    push("bypass_no_hazard", S_H2, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    idle();
    push("bypass_landed", S_RS2, 32'hA5A5A5A5);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [31:0] obs;
    tick();
    id_issue = 1'b1; id_rd = 5'd3; rs1_addr = 5'd3;
    push("sb_issue_same_cycle", S_H1, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    tick();
    idle();
    push("sb_cnt2_hazard", S_H1, 32'h1);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd3; wb_w_data = 32'h00000033;
    push("sb_first_wb_hazard", S_H1, 32'h1);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    wb_w_data = 32'h00000034;
    push("sb_last_wb_hazard", S_H1, BYPASS ? 32'h0 : 32'h1);
    push("sb_last_wb_data", S_RS1, BYPASS ? 32'h34 : 32'h33);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    idle();
    push("sb_drained_hazard", S_H1, 32'h0);
    push("sb_drained_data", S_RS1, 32'h34);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [31:0] obs;
    tick();
    id_issue = 1'b1; id_rd = 5'd9;
    tick();
    idle(); rs1_addr = 5'd9;
    push("sim_cnt1_hazard", S_H1, 32'h1);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    id_issue = 1'b1; id_rd = 5'd9;
    wb_w_req = 1'b1; wb_w_addr = 5'd9; wb_w_data = 32'h00000099;
    push("sim_same_cycle_hazard", S_H1, BYPASS ? 32'h0 : 32'h1);
    push("sim_same_cycle_data", S_RS1, BYPASS ? 32'h99 : 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    idle();
    push("sim_hazard_persists", S_H1, 32'h1);
    push("sim_data_written", S_RS1, 32'h99);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd9; wb_w_data = 32'h0000009A;
    tick();
    idle();
    push("sim_drained_hazard", S_H1, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  task automatic test_saturation_reset();
    exp_t e;
    logic [31:0] obs;
    tick();
    id_issue = 1'b1; id_rd = 5'd4; rs2_addr = 5'd4; rs1_addr = 5'd5;
    push("sat_err_clear_before", S_ERR, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    for (int i = 0; i < 4; i++) tick();
    idle();
    push("sat_hazard", S_H2, 32'h1);
    push("sat_err_set", S_ERR, 32'h1);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    wb_w_req = 1'b1; wb_w_addr = 5'd4; wb_w_data = 32'h00000044;
    tick();
    tick();
    idle();
    push("sat_cnt3_minus2_hazard", S_H2, 32'h1);
    push("sat_x4_data", S_RS2, 32'h44);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    rdy = 1'b0; rst_n = 1'b0;
    wb_w_req = 1'b1; wb_w_addr = 5'd5; wb_w_data = 32'hFFFFFFFF;
    tick();
    idle();
    push("rdy0_hazard_held", S_H2, 32'h1);
    push("rdy0_err_held", S_ERR, 32'h1);
    push("rdy0_no_write", S_RS1, 32'h12345678);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
    tick();
    rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    push("rst_hazard_cleared", S_H2, 32'h0);
    push("rst_err_cleared", S_ERR, 32'h0);
    push("rst_x5_cleared", S_RS1, 32'h0);
    push("rst_x4_cleared", S_RS2, 32'h0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); obs = observe(e.sig); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
      else $display("pass %s: %h", e.name, obs);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
